// File: rtl/max1452_pkg.sv
// -----------------------------------------------------------------------------
// max1452_pkg
//   Definitions shared by the MAX1452 single-wire configuration link.
//   - rx_state_e    : receive FSM state encoding
//   - DEF_CLK_DIV   : default system clocks per bit (50 MHz / 9600 baud)
//   - DEF_CNT_W     : default bit-timing counter width (2^13 > 5208)
//   - EOS_MARKER    : end-of-sequence byte also used by the transmit path
//   - half_bit_last : terminal count used to reach the middle of the start bit
// -----------------------------------------------------------------------------
package max1452_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  localparam int DEF_CLK_DIV = 5208;
  localparam int DEF_CNT_W   = 13;

  localparam logic [7:0] EOS_MARKER = 8'hfa;

  // Last count value of the half-bit wait in START. Integer division keeps
  // the start sample at the (lower) middle of the bit for odd dividers.
  function automatic int half_bit_last(input int clk_div);
    return (clk_div / 2) - 1;
  endfunction

endpackage : max1452_pkg

// File: rtl/max1452_rx_sync.sv
// -----------------------------------------------------------------------------
// max1452_rx_sync
//   Two-flop synchronizer for an asynchronous, idle-high input, followed by a
//   history register that flags a falling edge of the synchronized level.
//
// Ports
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   async_i  in   asynchronous input line (idle high)
//   sync_o   out  synchronized line level
//   fall_o   out  one-cycle flag: synchronized line went 1 -> 0
// -----------------------------------------------------------------------------
module max1452_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;   // previous synchronized level for edge detection
  logic [1:0] fill_q;   // number of stages already holding real line samples

  // The three stages reset to 1 (idle). Those reset values are placeholders,
  // not observations of the line, so the detector is only armed once every
  // stage has been refilled from the pin. Otherwise a line that is already
  // low when reset releases would look like a fresh 1 -> 0 start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fill_q <= 2'd0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (fill_q != 2'd3) begin
        fill_q <= fill_q + 2'd1;
      end
    end
  end

  assign sync_o = sync_q;
  assign fall_o = (fill_q == 2'd3) & prev_q & ~sync_q;

endmodule : max1452_rx_sync

// File: rtl/max1452_uart_rx.sv
// -----------------------------------------------------------------------------
// max1452_uart_rx
//   Receive side of the MAX1452 DIO/UART readback link. Decodes 8N1 frames,
//   strobes each good byte, and pairs consecutive good bytes into 16-bit
//   readback words (low byte first).
//
// Parameters
//   CLK_DIV  system clocks per bit (>= 8)
//   CNT_W    bit-timing counter width (2^CNT_W > CLK_DIV)
//
// Ports
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   rs_rx       in   asynchronous serial input, idle high
//   rx_data     out  last good byte, held
//   rx_valid    out  one-cycle strobe: new good byte on rx_data
//   frame_err   out  one-cycle strobe: stop bit sampled low
//   rx_word     out  {second byte, first byte}, held
//   word_valid  out  one-cycle strobe: new rx_word
//   rx_busy     out  high while the receiver is not idle
// -----------------------------------------------------------------------------
module max1452_uart_rx
  import max1452_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rs_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic [15:0] rx_word,
  output logic        word_valid,
  output logic        rx_busy
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_last(CLK_DIV));
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic rx_s;      // synchronized line level
  logic rx_fall;   // synchronized falling edge

  max1452_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (rs_rx),
    .sync_o  (rx_s),
    .fall_o  (rx_fall)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM, bit timer and shift register
  // ---------------------------------------------------------------------------
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             frame_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (rx_fall) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end

        // Re-check the line at the middle of the start bit so a short low
        // glitch is dropped without any strobe.
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q   <= ST_DATA;
              bit_idx_q <= 3'd0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Samples land one full bit after the previous mid-bit sample.
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[7:1]};   // LSB arrives first
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back
        // start edge from IDLE.
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // A held-low line (break) must not restart framing; wait for idle so
        // it yields exactly one frame error.
        ST_WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Word assembler: pairs consecutive good bytes, low byte first. A framing
  // error discards any pending low byte so pairing restarts cleanly.
  // ---------------------------------------------------------------------------
  logic        half_q;
  logic        half_d;
  logic [7:0]  low_q;
  logic [7:0]  low_d;
  logic [15:0] rx_word_q;
  logic [15:0] rx_word_d;
  logic        word_valid_q;
  logic        word_valid_d;

  always_comb begin
    half_d       = half_q;
    low_d        = low_q;
    rx_word_d    = rx_word_q;
    word_valid_d = 1'b0;
    if (frame_err_q) begin
      half_d = 1'b0;
    end else if (rx_valid_q) begin
      if (!half_q) begin
        low_d  = rx_data_q;
        half_d = 1'b1;
      end else begin
        rx_word_d    = {rx_data_q, low_q};
        word_valid_d = 1'b1;
        half_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_q       <= 1'b0;
      low_q        <= 8'h00;
      rx_word_q    <= 16'h0000;
      word_valid_q <= 1'b0;
    end else begin
      half_q       <= half_d;
      low_q        <= low_d;
      rx_word_q    <= rx_word_d;
      word_valid_q <= word_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all driven straight from registers)
  // ---------------------------------------------------------------------------
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign rx_word    = rx_word_q;
  assign word_valid = word_valid_q;
  assign rx_busy    = (state_q != ST_IDLE);

endmodule : max1452_uart_rx

// File: tb/tb_max1452_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_max1452_uart_rx
//   Directed bench for max1452_uart_rx with CLK_DIV = 16.
// -----------------------------------------------------------------------------
module tb_max1452_uart_rx;

  localparam int CLK_DIV = 16;
  localparam int CNT_W   = 5;
  // rs_rx driven in cycle N -> synchronized low (T0) in N+2 ->
  // strobe at T0 + CLK_DIV/2 + 9*CLK_DIV + 1.
  localparam int VALID_LAT = 2 + CLK_DIV/2 + 9*CLK_DIV + 1;
  // Busy from T0+1 up to and including the stop-sample cycle.
  localparam int BUSY_FRAME = CLK_DIV/2 + 9*CLK_DIV;

  logic        clk;
  logic        rst_n;
  logic        rs_rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic [15:0] rx_word;
  logic        word_valid;
  logic        rx_busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_word = 0;
  int n_busy = 0;
  int last_valid_cyc = 0;
  int last_word_cyc = 0;
  int start_cyc = 0;

  int b_valid, b_ferr, b_word, b_busy;

  max1452_uart_rx #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_rx      (rs_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .rx_word    (rx_word),
    .word_valid (word_valid),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
      end
      if (frame_err) n_ferr++;
      if (word_valid) begin
        n_word++;
        last_word_cyc = cyc;
      end
      if (rx_busy) n_busy++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_ferr  = n_ferr;
    b_word  = n_word;
    b_busy  = n_busy;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame; entered and left 1 time unit after a clock edge.
  // rst_slot selects a frame slot (0 = start, 1..8 = data, 9 = stop) in whose
  // middle a one-cycle reset pulse is applied; -1 for none.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rst_slot);
    logic b;
    $display("TX byte 0x%02h stop=%0d reset_slot=%0d", d, stop, rst_slot);
    for (int s = 0; s < 10; s++) begin
      if (s == 0)      b = 1'b0;
      else if (s == 9) b = stop;
      else             b = d[s-1];
      rs_rx = b;
      if (s == 0) start_cyc = cyc;
      if (s == rst_slot) begin
        idle(CLK_DIV/2);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(CLK_DIV - CLK_DIV/2 - 1);
      end else begin
        idle(CLK_DIV);
      end
    end
    rs_rx = 1'b1;
  endtask

  initial begin
    rs_rx = 1'b1;
    rst_n = 1'b0;

    // ---------------- Reset state ----------------
    do_reset(3);
    idle(4);
    check("reset_rx_data",    32'(rx_data),    32'h00);
    check("reset_rx_valid",   32'(rx_valid),   32'h0);
    check("reset_frame_err",  32'(frame_err),  32'h0);
    check("reset_rx_word",    32'(rx_word),    32'h0000);
    check("reset_word_valid", 32'(word_valid), 32'h0);
    check("reset_rx_busy",    32'(rx_busy),    32'h0);

    // ---------------- S1: single byte 0xA5 ----------------
    snap();
    send_frame(8'hA5, 1'b1, -1);
    idle(4);
    check("s1_valid_count", 32'(n_valid - b_valid), 32'd1);
    check("s1_rx_data",     32'(rx_data),           32'hA5);
    check("s1_ferr_count",  32'(n_ferr - b_ferr),   32'd0);
    check("s1_valid_cycle", 32'(last_valid_cyc),    32'(start_cyc + VALID_LAT));
    check("s1_busy_cycles", 32'(n_busy - b_busy),   32'(BUSY_FRAME));
    check("s1_word_count",  32'(n_word - b_word),   32'd0);

    // ---------------- S2: back-to-back 0x34, 0x12 ----------------
    do_reset(2);
    idle(4);
    snap();
    send_frame(8'h34, 1'b1, -1);
    send_frame(8'h12, 1'b1, -1);
    idle(4);
    check("s2_valid_count", 32'(n_valid - b_valid), 32'd2);
    check("s2_word_count",  32'(n_word - b_word),   32'd1);
    check("s2_rx_word",     32'(rx_word),           32'h1234);
    check("s2_rx_data",     32'(rx_data),           32'h12);
    check("s2_word_cycle",  32'(last_word_cyc),     32'(last_valid_cyc + 1));
    check("s2_valid_cycle", 32'(last_valid_cyc),    32'(start_cyc + VALID_LAT));

    // ---------------- S3: 4-cycle glitch ----------------
    snap();
    $display("TX glitch low 4 cycles");
    rs_rx = 1'b0;
    idle(4);
    rs_rx = 1'b1;
    idle(30);
    check("s3_busy_cycles", 32'(n_busy - b_busy),   32'(CLK_DIV/2));
    check("s3_busy_now",    32'(rx_busy),           32'h0);
    check("s3_valid_count", 32'(n_valid - b_valid), 32'd0);
    check("s3_ferr_count",  32'(n_ferr - b_ferr),   32'd0);

    // ---------------- S4: framing error restarts pairing ----------------
    send_frame(8'h77, 1'b1, -1);
    idle(4);
    check("s4_pre_rx_data", 32'(rx_data), 32'h77);
    snap();
    send_frame(8'h55, 1'b0, -1);
    rs_rx = 1'b0;              // break: hold low after the bad stop bit
    idle(40);
    check("s4_busy_in_break", 32'(rx_busy),           32'h1);
    check("s4_ferr_count",    32'(n_ferr - b_ferr),   32'd1);
    check("s4_valid_count",   32'(n_valid - b_valid), 32'd0);
    check("s4_rx_data_held",  32'(rx_data),           32'h77);
    rs_rx = 1'b1;
    idle(CLK_DIV);
    check("s4_busy_after",    32'(rx_busy),           32'h0);
    snap();
    send_frame(8'h0F, 1'b1, -1);
    send_frame(8'h0E, 1'b1, -1);
    idle(4);
    check("s4_word_count",    32'(n_word - b_word),   32'd1);
    check("s4_rx_word",       32'(rx_word),           32'h0E0F);
    check("s4_ferr_total",    32'(n_ferr - b_ferr),   32'd0);

    // ---------------- S5: reset during data bit 3 ----------------
    do_reset(2);
    idle(4);
    snap();
    send_frame(8'hFF, 1'b1, 4);
    idle(4);
    check("s5_abort_valid",   32'(n_valid - b_valid), 32'd0);
    check("s5_abort_ferr",    32'(n_ferr - b_ferr),   32'd0);
    check("s5_abort_rx_data", 32'(rx_data),           32'h00);
    check("s5_abort_busy",    32'(rx_busy),           32'h0);
    send_frame(8'h3C, 1'b1, -1);
    idle(4);
    check("s5_valid_count",   32'(n_valid - b_valid), 32'd1);
    check("s5_rx_data",       32'(rx_data),           32'h3C);
    check("s5_rx_word",       32'(rx_word),           32'h0000);
    check("s5_word_count",    32'(n_word - b_word),   32'd0);

    // ---------------- S6: line low across reset release ----------------
    $display("TX line held low across reset");
    rs_rx = 1'b0;
    do_reset(3);
    snap();
    idle(50);
    check("s6_busy_cycles", 32'(n_busy - b_busy),   32'd0);
    check("s6_valid_count", 32'(n_valid - b_valid), 32'd0);
    check("s6_ferr_count",  32'(n_ferr - b_ferr),   32'd0);
    rs_rx = 1'b1;
    idle(CLK_DIV);
    send_frame(8'h01, 1'b1, -1);
    idle(4);
    check("s6_valid_after", 32'(n_valid - b_valid), 32'd1);
    check("s6_rx_data",     32'(rx_data),           32'h01);
    check("s6_ferr_after",  32'(n_ferr - b_ferr),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_max1452_uart_rx
